// File: rtl/freq_ctrl_pkg.sv
// Purpose: shared register offsets, CTRL bit positions and sweep FSM states for freq_sweep_ctrl.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package freq_ctrl_pkg;

    // Register offsets within a channel (cfg_addr[2:0])
    localparam logic [2:0] REG_STEP  = 3'd0;
    localparam logic [2:0] REG_START = 3'd1;
    localparam logic [2:0] REG_STOP  = 3'd2;
    localparam logic [2:0] REG_DELTA = 3'd3;
    localparam logic [2:0] REG_DWELL = 3'd4;
    localparam logic [2:0] REG_CTRL  = 3'd5;

    // CTRL register bit positions
    localparam int CTRL_GO   = 0;
    localparam int CTRL_LOOP = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        HOLD  = 2'd2
    } sweep_state_t;

endpackage

// File: rtl/freq_sweep_channel.sv
// Purpose: one NCO channel - static step register plus linear/looping frequency sweep FSM.
// Latency: register writes and GO/abort show on step_out one cycle after the accepted write.
// Backpressure: none; every write presented is consumed. Build option: SWEEP_TRIANGLE_EN.
module freq_sweep_channel
    import freq_ctrl_pkg::*;
#(
    parameter int ACC_WIDTH   = 32,
    parameter int DWELL_WIDTH = 16
) (
    input  logic                   aclk,
    input  logic                   arst,
    input  logic                   wr_en,
    input  logic [2:0]             wr_reg,
    input  logic [ACC_WIDTH-1:0]   wr_data,
    output logic [ACC_WIDTH-1:0]   step_out,
    output logic                   sweep_busy,
    output logic                   sweep_done
);

    localparam logic [DWELL_WIDTH-1:0] DWELL_ONE = {{(DWELL_WIDTH-1){1'b0}}, 1'b1};

    // Programmed (shadow) registers; only sampled into the working copies on GO
    logic [ACC_WIDTH-1:0]   step_reg;
    logic [ACC_WIDTH-1:0]   start_reg;
    logic [ACC_WIDTH-1:0]   stop_reg;
    logic [ACC_WIDTH-1:0]   delta_reg;
    logic [DWELL_WIDTH-1:0] dwell_reg;

    // Working copies used by the running sweep
    logic [ACC_WIDTH-1:0]   w_start;
    logic [ACC_WIDTH-1:0]   w_stop;
    logic [ACC_WIDTH-1:0]   w_delta;
    logic [DWELL_WIDTH-1:0] w_dwell;
    logic                   w_loop;
    logic [ACC_WIDTH-1:0]   cur;
    logic [DWELL_WIDTH-1:0] dwell_cnt;
    sweep_state_t           state;
`ifndef SWEEP_TRIANGLE_EN
    // Set while STOP is displayed in sawtooth mode: next point reloads START
    logic                   wrap_pending;
`endif

    logic                   go_wr;
    logic                   halt_wr;
    logic [ACC_WIDTH-1:0]   step_nxt;
    logic [ACC_WIDTH:0]     nxt_sum;
    logic                   reach_stop;
    logic                   term;

    assign go_wr    = wr_en && (wr_reg == REG_CTRL) &&  wr_data[CTRL_GO];
    assign halt_wr  = wr_en && (wr_reg == REG_CTRL) && !wr_data[CTRL_GO];
    assign step_nxt = (wr_en && (wr_reg == REG_STEP)) ? wr_data : step_reg;

    // Next point with one guard bit: bit ACC_WIDTH flags carry (DELTA>0) or borrow (DELTA<0)
    assign nxt_sum    = {1'b0, cur} + {w_delta[ACC_WIDTH-1], w_delta};
    assign reach_stop = w_delta[ACC_WIDTH-1] ? (nxt_sum[ACC_WIDTH-1:0] <= w_stop)
                                             : (nxt_sum[ACC_WIDTH-1:0] >= w_stop);
    assign term       = (w_delta == '0) || nxt_sum[ACC_WIDTH] || reach_stop;

    // Programmed register file, written by the config port
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            step_reg  <= '0;
            start_reg <= '0;
            stop_reg  <= '0;
            delta_reg <= '0;
            dwell_reg <= '0;
        end else if (wr_en) begin
            case (wr_reg)
                REG_STEP:  step_reg  <= wr_data;
                REG_START: start_reg <= wr_data;
                REG_STOP:  stop_reg  <= wr_data;
                REG_DELTA: delta_reg <= wr_data;
                REG_DWELL: dwell_reg <= wr_data[DWELL_WIDTH-1:0];
                default:   ;
            endcase
        end
    end

    // Sweep FSM with registered step/busy/done outputs
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state        <= IDLE;
            w_start      <= '0;
            w_stop       <= '0;
            w_delta      <= '0;
            w_dwell      <= '0;
            w_loop       <= 1'b0;
            cur          <= '0;
            dwell_cnt    <= '0;
            step_out     <= '0;
            sweep_busy   <= 1'b0;
            sweep_done   <= 1'b0;
`ifndef SWEEP_TRIANGLE_EN
            wrap_pending <= 1'b0;
`endif
        end else begin
            sweep_done <= 1'b0;
            if (go_wr) begin
                w_start      <= start_reg;
                w_stop       <= stop_reg;
                w_delta      <= delta_reg;
                w_dwell      <= dwell_reg;
                w_loop       <= wr_data[CTRL_LOOP];
                cur          <= start_reg;
                dwell_cnt    <= '0;
                step_out     <= start_reg;
                sweep_busy   <= 1'b1;
                state        <= SWEEP;
`ifndef SWEEP_TRIANGLE_EN
                wrap_pending <= 1'b0;
`endif
            end else if (halt_wr) begin
                state      <= IDLE;
                step_out   <= step_nxt;
                sweep_busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        step_out <= step_nxt;
                    end
                    SWEEP: begin
                        if (dwell_cnt == w_dwell) begin
                            dwell_cnt <= '0;
`ifndef SWEEP_TRIANGLE_EN
                            if (wrap_pending) begin
                                cur          <= w_start;
                                step_out     <= w_start;
                                wrap_pending <= 1'b0;
                            end else
`endif
                            if (term) begin
                                // Clamp to STOP; never let the step wrap
                                cur      <= w_stop;
                                step_out <= w_stop;
                                if (!w_loop) begin
                                    state      <= HOLD;
                                    sweep_busy <= 1'b0;
                                    sweep_done <= 1'b1;
                                end else begin
`ifdef SWEEP_TRIANGLE_EN
                                    // Bounce: reverse direction and swap the endpoints
                                    w_delta <= -w_delta;
                                    w_start <= w_stop;
                                    w_stop  <= w_start;
`else
                                    wrap_pending <= 1'b1;
`endif
                                end
                            end else begin
                                cur      <= nxt_sum[ACC_WIDTH-1:0];
                                step_out <= nxt_sum[ACC_WIDTH-1:0];
                            end
                        end else begin
                            dwell_cnt <= dwell_cnt + DWELL_ONE;
                        end
                    end
                    HOLD: begin
                        step_out <= w_stop;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/freq_sweep_ctrl.sv
// Purpose: multi-channel NCO step/sweep controller; decodes config writes and packs channel outputs.
// Latency: accepted write affects step_out/sweep_busy one cycle later.
// Backpressure: none; cfg_ready is held high once out of reset. Build option: SWEEP_TRIANGLE_EN.
module freq_sweep_ctrl
    import freq_ctrl_pkg::*;
#(
    parameter  int NUM_CH      = 2,
    parameter  int ACC_WIDTH   = 32,
    parameter  int DWELL_WIDTH = 16,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                          aclk,
    input  logic                          arst,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [CH_W+2:0]               cfg_addr,
    input  logic [ACC_WIDTH-1:0]          cfg_data,
    output logic [NUM_CH*ACC_WIDTH-1:0]   step_out,
    output logic [NUM_CH-1:0]             sweep_busy,
    output logic [NUM_CH-1:0]             sweep_done
);

    logic              wr_acc;
    logic [CH_W-1:0]   ch_sel;
    logic [2:0]        reg_sel;
    logic [NUM_CH-1:0] ch_wr;

    assign wr_acc  = cfg_valid && cfg_ready;
    assign ch_sel  = cfg_addr[CH_W+2:3];
    assign reg_sel = cfg_addr[2:0];

    // Ready rises on the first clock after reset and stays up
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            cfg_ready <= 1'b0;
        end else begin
            cfg_ready <= 1'b1;
        end
    end

    // Channel indices >= NUM_CH match no channel, so those writes are dropped
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign ch_wr[i] = wr_acc && (ch_sel == CH_W'(i));

        freq_sweep_channel #(
            .ACC_WIDTH   (ACC_WIDTH),
            .DWELL_WIDTH (DWELL_WIDTH)
        ) u_channel (
            .aclk       (aclk),
            .arst       (arst),
            .wr_en      (ch_wr[i]),
            .wr_reg     (reg_sel),
            .wr_data    (cfg_data),
            .step_out   (step_out[i*ACC_WIDTH +: ACC_WIDTH]),
            .sweep_busy (sweep_busy[i]),
            .sweep_done (sweep_done[i])
        );
    end

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Purpose: directed self-checking bench for freq_sweep_ctrl (three channels, 32-bit steps).
// Latency: checks sample 1 time unit after the rising edge that applied the stimulus.
// Backpressure: n/a.
module tb_freq_sweep_ctrl;

    localparam int NUM_CH = 3;
    localparam int ACCW   = 32;
    localparam int CH_W   = 2;

    logic                      aclk;
    logic                      arst;
    logic                      cfg_valid;
    logic                      cfg_ready;
    logic [CH_W+2:0]           cfg_addr;
    logic [ACCW-1:0]           cfg_data;
    logic [NUM_CH*ACCW-1:0]    step_out;
    logic [NUM_CH-1:0]         sweep_busy;
    logic [NUM_CH-1:0]         sweep_done;

    int n_vec;
    int n_err;
    int loop_exp [6];

    freq_sweep_ctrl #(
        .NUM_CH      (NUM_CH),
        .ACC_WIDTH   (ACCW),
        .DWELL_WIDTH (16)
    ) dut (
        .aclk       (aclk),
        .arst       (arst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .step_out   (step_out),
        .sweep_busy (sweep_busy),
        .sweep_done (sweep_done)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic wr(input int ch, input int rg, input logic [31:0] d);
        logic [1:0] c;
        logic [2:0] r;
        c = ch[1:0];
        r = rg[2:0];
        cfg_valid = 1'b1;
        cfg_addr  = {c, r};
        cfg_data  = d;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic setup(input int ch, input logic [31:0] st, input logic [31:0] sp,
                         input logic [31:0] dl, input logic [31:0] dw);
        wr(ch, 1, st);
        wr(ch, 2, sp);
        wr(ch, 3, dl);
        wr(ch, 4, dw);
    endtask

    initial begin
        bit seen;
        n_vec     = 0;
        n_err     = 0;
        arst      = 1'b1;
        cfg_valid = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
`ifdef SWEEP_TRIANGLE_EN
        loop_exp = '{0, 4, 8, 4, 0, 4};
`else
        loop_exp = '{0, 4, 8, 0, 4, 8};
`endif

        // Reset state
        tick();
        tick();
        chk("rst_step", step_out, 96'd0);
        chk("rst_busy", sweep_busy, 96'd0);
        chk("rst_done", sweep_done, 96'd0);
        chk("rst_ready", cfg_ready, 96'd0);
        arst = 1'b0;
        #1;
        chk("ready_before_edge", cfg_ready, 96'd0);
        tick();
        chk("ready_after_edge", cfg_ready, 96'd1);

        // Static step on ch1, ch0 untouched
        wr(1, 0, 32'h0100_0000);
        chk("static_ch1", step_out[63:32], 96'h0100_0000);
        chk("static_ch0", step_out[31:0], 96'd0);
        wr(0, 0, 32'h0000_1234);
        chk("static_ch0_b", step_out[31:0], 96'h1234);

        // Writes to channel index NUM_CH are ignored
        wr(3, 0, 32'hDEAD_BEEF);
        wr(3, 5, 32'h1);
        tick();
        chk("badch_step", step_out, {32'd0, 32'h0100_0000, 32'h1234});
        chk("badch_busy", sweep_busy, 96'd0);

        // Up-sweep: 100,110,120,130, three cycles each, done with first 130
        setup(0, 100, 130, 10, 2);
        wr(0, 5, 32'h1);
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 3; k++) begin
                chk("up_step", step_out[31:0], 96'(100 + 10 * p));
                chk("up_done", sweep_done[0], 96'((p == 3 && k == 0) ? 1 : 0));
                chk("up_busy", sweep_busy[0], 96'((p < 3) ? 1 : 0));
                tick();
            end
        end
        chk("hold_step", step_out[31:0], 96'd130);
        chk("hold_busy", sweep_busy[0], 96'd0);
        wr(0, 5, 32'h0);
        chk("hold_exit_step", step_out[31:0], 96'h1234);
        chk("hold_exit_done", sweep_done[0], 96'd0);

        // Down-sweep with clamp at STOP
        setup(0, 50, 5, 32'hFFFF_FFEC, 0);
        wr(0, 5, 32'h1);
        chk("dn_0", step_out[31:0], 96'd50);
        tick();
        chk("dn_1", step_out[31:0], 96'd30);
        tick();
        chk("dn_2", step_out[31:0], 96'd10);
        chk("dn_2_done", sweep_done[0], 96'd0);
        tick();
        chk("dn_3", step_out[31:0], 96'd5);
        chk("dn_3_done", sweep_done[0], 96'd1);

        // Carry-out clamps instead of wrapping
        setup(0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 0);
        wr(0, 5, 32'h1);
        chk("wrap_0", step_out[31:0], 96'hFFFF_FFF0);
        tick();
        chk("wrap_1", step_out[31:0], 96'hFFFF_FFFF);
        chk("wrap_1_done", sweep_done[0], 96'd1);

        // DELTA=0: one point at START then STOP
        setup(0, 7, 99, 0, 0);
        wr(0, 5, 32'h1);
        chk("dz_0", step_out[31:0], 96'd7);
        tick();
        chk("dz_1", step_out[31:0], 96'd99);
        chk("dz_1_done", sweep_done[0], 96'd1);

        // Looping sweep, then abort with GO=0
        setup(0, 0, 8, 4, 0);
        wr(0, 5, 32'h3);
        for (int i = 0; i < 6; i++) begin
            chk("loop_step", step_out[31:0], 96'(loop_exp[i]));
            chk("loop_done", sweep_done[0], 96'd0);
            chk("loop_busy", sweep_busy[0], 96'd1);
            tick();
        end
        wr(0, 5, 32'h0);
        chk("abort_step", step_out[31:0], 96'h1234);
        chk("abort_busy", sweep_busy[0], 96'd0);
        chk("abort_done", sweep_done[0], 96'd0);

        // Shadowing: STOP rewrite mid-sweep does not move the running endpoint
        setup(0, 0, 30, 10, 1);
        wr(0, 5, 32'h1);
        wr(0, 2, 32'd999);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (sweep_done[0]) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("shadow_done_seen", seen, 96'd1);
        chk("shadow_stop", step_out[31:0], 96'd30);
        chk("shadow_ch1", step_out[63:32], 96'h0100_0000);

        // Async reset in the middle of a sweep
        setup(1, 16, 1000, 1, 0);
        wr(1, 5, 32'h1);
        tick();
        chk("pre_rst_busy", sweep_busy[1], 96'd1);
        arst = 1'b1;
        #1;
        chk("midrst_step", step_out, 96'd0);
        chk("midrst_busy", sweep_busy, 96'd0);
        chk("midrst_ready", cfg_ready, 96'd0);
        tick();
        arst = 1'b0;
        tick();
        chk("post_rst_ready", cfg_ready, 96'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
